// File: rtl/ifu_pkg.sv
// Shared fetch definitions: next-PC select codes, reset/base address and
// the branch offset helper used by the next-PC logic.
package ifu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_JAL = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] PC_BASE = 32'h0000_3000;

  // Sign-extended, word-scaled beq displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC logic: sequential, beq, jal and jr targets.
// Unknown select codes fall through to sequential fetch.
module npc
  import ifu_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [25:0] Imm26,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic [31:0] RegData,
  output logic [31:0] NPC,
  output logic [31:0] PC4
);

  // jr drops the low two bits, so they are intentionally unused.
  logic unused_regdata;
  assign unused_regdata = ^RegData[1:0];

  assign PC4 = PC + 32'd4;

  // Select the next PC; default keeps a non-decoded select on PC+4.
  always_comb begin
    NPC = PC4;
    case (NPCOp)
      NPC_BEQ: if (Zero) NPC = PC4 + branch_offset(Imm26[15:0]);
      NPC_JAL: NPC = {PC[31:28], Imm26, 2'b00};
      NPC_JR:  NPC = {RegData[31:2], 2'b00};
      default: NPC = PC4;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, read-only instruction ROM, ROM window
// check and sticky fault hold. The ROM image arrives as IM_INIT, with word i
// at bits [32*i +: 32], so the ROM elaborates as constant logic.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0]            PC_RESET = PC_BASE,
  parameter int unsigned            IM_DEPTH = 1024,
  parameter logic [32*IM_DEPTH-1:0] IM_INIT  = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic [31:0] RegData,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Fault
);

  localparam int unsigned IDX_W = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;

  logic [31:0]      rom [IM_DEPTH];
  logic [31:0]      pc_off;
  logic [29:0]      word_off;
  logic [1:0]       unused_align;
  logic [IDX_W-1:0] rom_idx;
  logic             in_range;
  logic [31:0]      next_pc;

  for (genvar i = 0; i < IM_DEPTH; i++) begin : g_rom
    assign rom[i] = IM_INIT[32*i +: 32];
  end

  assign pc_off       = PC - PC_RESET;
  assign word_off     = pc_off[31:2];
  assign unused_align = pc_off[1:0];
  assign rom_idx      = word_off[IDX_W-1:0];
  assign in_range     = (PC >= PC_RESET) && ({2'b00, word_off} < IM_DEPTH);
  assign Instr        = in_range ? rom[rom_idx] : '0;

  npc u_npc (
    .PC      (PC),
    .Imm26   (Instr[25:0]),
    .NPCOp   (NPCOp),
    .Zero    (Zero),
    .RegData (RegData),
    .NPC     (next_pc),
    .PC4     (PC4)
  );

  // PC advances every edge until a fetch leaves the ROM window; from then on
  // the PC freezes and Fault stays set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC    <= PC_RESET;
      Fault <= 1'b0;
    end else if (Fault || !in_range) begin
      Fault <= 1'b1;
    end else begin
      PC <= next_pc;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: one main instance with a 16-word ROM and
// a 4-word instance for the end-of-window scenario.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [32*16-1:0] MAIN_IMG = {320'h0,
    32'h1111_1111, 32'hAABB_CCDD, 32'h0022_1820,
    32'h1000_FFFE, 32'h2401_0001, 32'h0C00_0C05};
  localparam logic [32*4-1:0] SMALL_IMG = {
    32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic        clk = 1'b0;
  logic        reset, zero;
  logic [1:0]  op;
  logic [31:0] regdata, instr, pc, pc4;
  logic        fault;

  logic        s_reset, s_zero;
  logic [1:0]  s_op;
  logic [31:0] s_regdata, s_instr, s_pc, s_pc4;
  logic        s_fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifu #(.PC_RESET(32'h0000_3000), .IM_DEPTH(16), .IM_INIT(MAIN_IMG)) dut (
    .clk(clk), .reset(reset), .NPCOp(op), .Zero(zero), .RegData(regdata),
    .Instr(instr), .PC(pc), .PC4(pc4), .Fault(fault)
  );

  ifu #(.PC_RESET(32'h0000_3000), .IM_DEPTH(4), .IM_INIT(SMALL_IMG)) dut_small (
    .clk(clk), .reset(s_reset), .NPCOp(s_op), .Zero(s_zero), .RegData(s_regdata),
    .Instr(s_instr), .PC(s_pc), .PC4(s_pc4), .Fault(s_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
    tests++; if (pc4 !== 32'h3004) begin fails++; $display("FAIL reset_pc4: got %h expected %h", pc4, 32'h3004); end
    tests++; if (instr !== 32'h0C00_0C05) begin fails++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0C000C05); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault); end
    tests++; if (s_pc !== 32'h3000) begin fails++; $display("FAIL small_reset_pc: got %h expected %h", s_pc, 32'h3000); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3]    = '{32'h3004, 32'h3008, 32'h300C};
    logic [31:0] exp_instr [3] = '{32'h2401_0001, 32'h1000_FFFE, 32'h0022_1820};
    op = NPC_SEQ;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc !== exp_pc[i]) begin fails++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
      tests++; if (pc4 !== exp_pc[i] + 32'd4) begin fails++; $display("FAIL seq_pc4[%0d]: got %h expected %h", i, pc4, exp_pc[i] + 32'd4); end
      tests++; if (instr !== exp_instr[i]) begin fails++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, exp_instr[i]); end
    end
  endtask

  task automatic test_async_reset();
    op = NPC_SEQ;
    tick();
    tests++; if (pc !== 32'h3010) begin fails++; $display("FAIL pre_reset_pc: got %h expected %h", pc, 32'h3010); end
    tests++; if (instr !== 32'hAABB_CCDD) begin fails++; $display("FAIL pre_reset_instr: got %h expected %h", instr, 32'hAABBCCDD); end
    #2 reset = 1'b1;
    #1;
    tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h3000); end
    tests++; if (instr !== 32'h0C00_0C05) begin fails++; $display("FAIL async_reset_instr: got %h expected %h", instr, 32'h0C000C05); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL async_reset_fault: got %b expected 0", fault); end
    op = NPC_JAL;
    tick();
    reset = 1'b0;
    tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_discards_jal: got %h expected %h", pc, 32'h3000); end
    op = NPC_SEQ;
  endtask

  task automatic test_beq();
    op = NPC_SEQ;
    tick(); tick();
    tests++; if (instr !== 32'h1000_FFFE) begin fails++; $display("FAIL beq_instr: got %h expected %h", instr, 32'h1000FFFE); end
    op = NPC_BEQ; zero = 1'b1;
    tick();
    tests++; if (pc !== 32'h3004) begin fails++; $display("FAIL beq_taken: got %h expected %h", pc, 32'h3004); end
    op = NPC_SEQ;
    tick();
    op = NPC_BEQ; zero = 1'b0;
    tick();
    tests++; if (pc !== 32'h300C) begin fails++; $display("FAIL beq_not_taken: got %h expected %h", pc, 32'h300C); end
    op = NPC_SEQ;
  endtask

  task automatic test_jal_jr();
    pulse_reset();
    tests++; if (pc4 !== 32'h3004) begin fails++; $display("FAIL jal_link: got %h expected %h", pc4, 32'h3004); end
    op = NPC_JAL;
    tick();
    tests++; if (pc !== 32'h3014) begin fails++; $display("FAIL jal_target: got %h expected %h", pc, 32'h3014); end
    tests++; if (instr !== 32'h1111_1111) begin fails++; $display("FAIL jal_instr: got %h expected %h", instr, 32'h11111111); end
    op = NPC_JR; regdata = 32'h3006;
    tick();
    tests++; if (pc !== 32'h3004) begin fails++; $display("FAIL jr_truncate: got %h expected %h", pc, 32'h3004); end
    tests++; if (instr !== 32'h2401_0001) begin fails++; $display("FAIL jr_instr: got %h expected %h", instr, 32'h24010001); end
  endtask

  task automatic test_top_of_window();
    op = NPC_JR; regdata = 32'h3018;
    tick();
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL unwritten_word: got %h expected 0", instr); end
    regdata = 32'h303C;
    tick();
    tests++; if (pc !== 32'h303C || fault !== 1'b0) begin fails++; $display("FAIL last_word: got pc %h fault %b expected 303c/0", pc, fault); end
    op = NPC_SEQ;
    tick();
    tests++; if (pc !== 32'h3040 || instr !== 32'h0 || fault !== 1'b0) begin fails++; $display("FAIL past_end: got pc %h instr %h fault %b expected 3040/0/0", pc, instr, fault); end
    tick();
    tests++; if (pc !== 32'h3040 || fault !== 1'b1) begin fails++; $display("FAIL past_end_fault: got pc %h fault %b expected 3040/1", pc, fault); end
    pulse_reset();
    tests++; if (pc !== 32'h3000 || fault !== 1'b0) begin fails++; $display("FAIL fault_clear: got pc %h fault %b expected 3000/0", pc, fault); end
  endtask

  task automatic test_jr_below_base();
    op = NPC_JR; regdata = 32'h2000;
    tick();
    tests++; if (pc !== 32'h2000 || instr !== 32'h0 || fault !== 1'b0) begin fails++; $display("FAIL below_base: got pc %h instr %h fault %b expected 2000/0/0", pc, instr, fault); end
    op = NPC_JAL;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc !== 32'h2000 || fault !== 1'b1) begin fails++; $display("FAIL below_base_hold[%0d]: got pc %h fault %b expected 2000/1", i, pc, fault); end
    end
    pulse_reset();
    op = NPC_SEQ;
  endtask

  task automatic test_small_rom();
    logic [31:0] exp_instr [4] = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0};
    s_reset = 1'b0;
    s_op = NPC_SEQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (s_pc !== 32'h3004 + 32'(4 * i) || s_instr !== exp_instr[i] || s_fault !== 1'b0) begin
        fails++; $display("FAIL small_seq[%0d]: got pc %h instr %h fault %b expected %h/%h/0", i, s_pc, s_instr, s_fault, 32'h3004 + 32'(4 * i), exp_instr[i]);
      end
    end
    s_op = NPC_JAL;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (s_pc !== 32'h3010 || s_fault !== 1'b1) begin fails++; $display("FAIL small_hold[%0d]: got pc %h fault %b expected 3010/1", i, s_pc, s_fault); end
    end
    s_reset = 1'b1;
    #1;
    s_reset = 1'b0;
    tests++; if (s_pc !== 32'h3000 || s_fault !== 1'b0 || s_instr !== 32'h1111_1111) begin
      fails++; $display("FAIL small_reset: got pc %h fault %b instr %h expected 3000/0/11111111", s_pc, s_fault, s_instr);
    end
  endtask

  initial begin
    reset = 1'b1; op = NPC_SEQ; zero = 1'b0; regdata = '0;
    s_reset = 1'b1; s_op = NPC_SEQ; s_zero = 1'b0; s_regdata = '0;
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_sequential();
    test_async_reset();
    test_beq();
    test_jal_jr();
    test_top_of_window();
    test_jr_below_base();
    test_small_rom();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
